// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands latched on start, summed LSB-first.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the sub port.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_n;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtract: a + ~b + 1, c_out=1 means no borrow.
  always_comb begin
    b_ld = sub ? ~b : b;
    c_ld = sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_ld = b;
    c_ld = c_in;
  end
`endif

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  always_comb begin
    res_n            = res_q >> 1;
    res_n[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_ld;
            carry_q <= c_ld;
            res_q   <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_n;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            sum   <= res_n;
            c_out <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, random model,
// 1-bit truth table, held-start handshake and mid-operation reset.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
  logic       busy, done, c_out;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub = 1'b0;
  logic       sub1 = 1'b0;
`endif

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c_in1 = 1'b0;
  logic       busy1, done1, c_out1;
  logic [0:0] sum1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .c_in(c_in1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Runs one 8-bit op; inputs are scrambled right after acceptance.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, output logic [7:0] os,
                      output logic oc, output int lat, output int bc);
    logic [7:0] prev;
    prev = sum;
    a = ia; b = ib; c_in = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    lat = 0; bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if (sum !== prev) chk("sum_hold", 32'(sum), 32'(prev));
      @(posedge clk); #1;
      lat++;
    end
    os = sum; oc = c_out;
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  vec_t vt[6];
  logic [7:0] rs;
  logic rc;
  int lat, bc;
  logic [8:0] model;
  logic [7:0] ha[40];
  logic [7:0] hb[40];
  logic       hc[40];
  logic [8:0] last_res;
  int ndone;

  initial begin
    vt[0] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run8(vt[i].a, vt[i].b, vt[i].ci, rs, rc, lat, bc);
      chk("vec_sum", 32'(rs), 32'(vt[i].s));
      chk("vec_cout", 32'(rc), 32'(vt[i].co));
      chk("vec_latency", 32'(lat), 32'd8);
      chk("vec_busy_cycles", 32'(bc), 32'd8);
    end

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic rci;
      ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rci);
      run8(ra, rb, rci, rs, rc, lat, bc);
      chk("rand_result", 32'({rc, rs}), 32'(model));
      chk("rand_latency", 32'(lat), 32'd8);
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      c_in1 = v[2]; a1 = v[1]; b1 = v[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      @(posedge clk); #1;
      chk("fa_done", 32'(done1), 32'd1);
      chk("fa_result", 32'({c_out1, sum1}), 32'($countones(v)));
      @(posedge clk); #1;
      chk("fa_done_clear", 32'(done1), 32'd0);
    end

    // Start held high: accepts at cycle 0, 10, 20; results at 8, 18, 28.
    last_res = {c_out, sum};
    ndone = 0;
    start = 1'b1;
    for (int j = 0; j < 30; j++) begin
      ha[j] = 8'($urandom); hb[j] = 8'($urandom); hc[j] = 1'($urandom);
      a = ha[j]; b = hb[j]; c_in = hc[j];
      @(posedge clk); #1;
      if ((j % 10) == 8) begin
        chk("hs_done", 32'(done), 32'd1);
        last_res = 9'(ha[j-8]) + 9'(hb[j-8]) + 9'(hc[j-8]);
        chk("hs_result", 32'({c_out, sum}), 32'(last_res));
      end else if (done) begin
        chk("hs_spurious_done", 32'(done), 32'd0);
      end else if ({c_out, sum} !== last_res) begin
        chk("hs_hold", 32'({c_out, sum}), 32'(last_res));
      end
      if (done) ndone++;
    end
    start = 1'b0;
    chk("hs_done_count", 32'(ndone), 32'd3);
    repeat (3) @(posedge clk);
    #1;

    a = 8'h3C; b = 8'h11; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_activity", 32'(ndone), 32'd0);
    run8(8'h3C, 8'h11, 1'b1, rs, rc, lat, bc);
    chk("after_abort", 32'({rc, rs}), 32'h04E);

    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_wins_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("rst_wins_idle", 32'(busy), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run8(8'h05, 8'h07, 1'b0, rs, rc, lat, bc);
    chk("sub_borrow", 32'({rc, rs}), 32'h0FE);
    sub = 1'b1;
    run8(8'h07, 8'h05, 1'b0, rs, rc, lat, bc);
    chk("sub_noborrow", 32'({rc, rs}), 32'h102);
    sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
